// File: rtl/tv_fb_scheduler.sv
// Purpose : shares the single-port 1bpp framebuffer RAM between the scanline prefetcher
//           (RAM -> line buffer copy, one line per line_req) and a host write port.
// Latency : a read issued in cycle t lands in the line buffer in cycle t+1; a line with
//           no host traffic keeps fetch_busy high for WORDS_PER_LINE+1 cycles.
// Backpressure: host_ready drops during a fetch, but a host slot is forced after
//           HOST_GAP consecutive fetch reads while host_valid is held.
//
// Ports:
//   clk, reset_ (async, active-low)
//   line_req/line_num           : line fetch request from the video timing counters
//   fetch_busy/underrun/underrun_clr : fetch status, sticky overrun flag and its clear
//   host_valid/host_ready/host_addr/host_data : host write port
//   mem_addr/mem_we/mem_wdata/mem_rdata       : framebuffer RAM port
//   lb_we/lb_addr/lb_data                     : line buffer write port
module tv_fb_scheduler #(
   parameter int WORDS_PER_LINE = 31,
   parameter int LINES          = 268,
   parameter int ADDR_W         = 14,
   parameter int HOST_GAP       = 8
) (
   input  logic              clk,
   input  logic              reset_,
   input  logic              line_req,
   input  logic [8:0]        line_num,
   output logic              fetch_busy,
   output logic              underrun,
   input  logic              underrun_clr,
   input  logic              host_valid,
   output logic              host_ready,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [15:0]       host_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [15:0]       mem_wdata,
   input  logic [15:0]       mem_rdata,
   output logic              lb_we,
   output logic [4:0]        lb_addr,
   output logic [15:0]       lb_data
);

   localparam int                GAP_W     = $clog2(HOST_GAP + 1);
   localparam logic [4:0]        LAST_WORD = 5'(WORDS_PER_LINE - 1);
   localparam logic [8:0]        LINES_L   = 9'(LINES);
   localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(HOST_GAP);
   localparam logic [ADDR_W-1:0] WPL_A     = ADDR_W'(WORDS_PER_LINE);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   base, base_nxt;
   logic [4:0]          word, word_nxt;
   logic [GAP_W-1:0]    gap, gap_nxt;
   logic                rd_vld, rd_vld_nxt;
   logic [4:0]          rd_idx;
   logic                underrun_nxt;
   logic                line_ok;
   logic                restart;
   logic                host_slot;
   logic                fetch_slot;
   logic [ADDR_W-1:0]   new_base;

   assign line_ok  = (line_num < LINES_L);
   assign new_base = ADDR_W'(line_num) * WPL_A;
   // A valid request while busy abandons the current line and starts over.
   assign restart  = line_req && line_ok && (state != IDLE);

   always_comb begin
      state_nxt  = state;
      base_nxt   = base;
      word_nxt   = word;
      gap_nxt    = gap;
      host_slot  = 1'b0;
      fetch_slot = 1'b0;
      host_ready = 1'b1;
      rd_vld_nxt = 1'b0;
      case (state)
         IDLE: begin
            gap_nxt = '0;
            if (line_req && line_ok) begin
               state_nxt = FETCH;
               base_nxt  = new_base;
               word_nxt  = '0;
            end
         end
         FETCH: begin
            host_slot  = host_valid && (gap == GAP_MAX);
            fetch_slot = !host_slot;
            host_ready = host_slot;
            // gap counts reads made while the host is kept waiting
            if (!host_valid || host_slot) begin
               gap_nxt = '0;
            end else if (gap != GAP_MAX) begin
               gap_nxt = gap + GAP_W'(1);
            end
            // the read launched in a restart cycle belongs to the old line: drop its data
            rd_vld_nxt = fetch_slot && !restart;
            if (fetch_slot) begin
               if (word == LAST_WORD) begin
                  state_nxt = DRAIN;
               end else begin
                  word_nxt = word + 5'd1;
               end
            end
         end
         DRAIN: begin
            gap_nxt   = '0;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      if (restart) begin
         state_nxt = FETCH;
         base_nxt  = new_base;
         word_nxt  = '0;
      end
   end

   // set has priority over clear so a request in the clear cycle is not lost
   always_comb begin
      underrun_nxt = underrun;
      if (line_req && fetch_busy) begin
         underrun_nxt = 1'b1;
      end else if (underrun_clr) begin
         underrun_nxt = 1'b0;
      end
   end

   assign fetch_busy = (state != IDLE);
   assign mem_we     = host_valid && host_ready;
   assign mem_addr   = fetch_slot ? (base + ADDR_W'(word)) : host_addr;
   assign mem_wdata  = host_data;
   assign lb_we      = rd_vld;
   assign lb_addr    = rd_idx;
   assign lb_data    = mem_rdata;

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state    <= IDLE;
         base     <= '0;
         word     <= '0;
         gap      <= '0;
         rd_vld   <= 1'b0;
         rd_idx   <= '0;
         underrun <= 1'b0;
      end else begin
         state    <= state_nxt;
         base     <= base_nxt;
         word     <= word_nxt;
         gap      <= gap_nxt;
         rd_vld   <= rd_vld_nxt;
         rd_idx   <= word;
         underrun <= underrun_nxt;
      end
   end

endmodule

// File: tb/tb_tv_fb_scheduler.sv
// Purpose : directed bench for tv_fb_scheduler with a line-level reference model.
// Latency : model predicts every output each cycle; literal checks pin key numbers.
// Backpressure: host stream advances only on accepted writes.
module tb_tv_fb_scheduler;

   logic        clk = 1'b0;
   logic        reset_;
   logic        line_req;
   logic [8:0]  line_num;
   logic        fetch_busy;
   logic        underrun;
   logic        underrun_clr;
   logic        host_valid;
   logic        host_ready;
   logic [13:0] host_addr;
   logic [15:0] host_data;
   logic [13:0] mem_addr;
   logic        mem_we;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        lb_we;
   logic [4:0]  lb_addr;
   logic [15:0] lb_data;

   tv_fb_scheduler dut (
      .clk          (clk),
      .reset_       (reset_),
      .line_req     (line_req),
      .line_num     (line_num),
      .fetch_busy   (fetch_busy),
      .underrun     (underrun),
      .underrun_clr (underrun_clr),
      .host_valid   (host_valid),
      .host_ready   (host_ready),
      .host_addr    (host_addr),
      .host_data    (host_data),
      .mem_addr     (mem_addr),
      .mem_we       (mem_we),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .lb_we        (lb_we),
      .lb_addr      (lb_addr),
      .lb_data      (lb_data)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, act, exp);
      end
   endtask

   // initial RAM contents: an odd multiplier keeps every address distinct
   function automatic logic [15:0] pat(input int a);
      return 16'(a * 40503 + 4660);
   endfunction

   // framebuffer RAM stand-in, one cycle read latency
   logic [15:0] ram [0:16383];
   bit          ram_ok = 1'b0;
   always @(posedge clk) begin
      if (!ram_ok) begin
         for (int i = 0; i < 16384; i++) ram[i] = pat(i);
         ram_ok = 1'b1;
      end else begin
         mem_rdata <= ram[mem_addr];
         if (mem_we) ram[mem_addr] = mem_wdata;
      end
   end

   // reference model: line-level view of the scheduler
   logic [15:0] mram [0:16383];
   bit          mram_ok = 1'b0;
   bit          m_busy, m_drain, m_und, m_pend;
   int          m_base, m_next, m_gap, m_pidx;
   logic [15:0] m_pdat;
   bit          ht, ft, er, ew, ab, ok_l, np;
   int          nidx;
   logic [15:0] ndat;

   // observation statistics
   logic [15:0] lb_cap [0:31];
   int  cyc = 0, busy_tot = 0, lbwe_tot = 0, hwb_tot = 0;
   int  busy_rise = -1, rise_addr = -1, lb_rise = -1, lb_last = -1;
   bit  lb_prev = 1'b0, busy_prev = 1'b0;

   always @(negedge clk) begin
      if (!mram_ok) begin
         for (int i = 0; i < 16384; i++) mram[i] = pat(i);
         mram_ok = 1'b1;
      end
      if (!reset_) begin
         m_busy = 0; m_drain = 0; m_und = 0; m_pend = 0;
         m_base = 0; m_next = 0; m_gap = 0;
         chk("rst_fetch_busy", int'(fetch_busy), 0);
         chk("rst_underrun", int'(underrun), 0);
         chk("rst_lb_we", int'(lb_we), 0);
         lb_prev = 0; busy_prev = 0;
      end else begin
         ht = m_busy && !m_drain && host_valid && (m_gap == 8);
         ft = m_busy && !m_drain && !ht;
         er = !(m_busy && !m_drain) || ht;
         ew = host_valid && er;
         chk("fetch_busy", int'(fetch_busy), int'(m_busy));
         chk("underrun", int'(underrun), int'(m_und));
         chk("host_ready", int'(host_ready), int'(er));
         chk("mem_we", int'(mem_we), int'(ew));
         chk("lb_we", int'(lb_we), int'(m_pend));
         if (ft) begin
            chk("mem_addr_read", int'(mem_addr), m_base + m_next);
         end else if (ew) begin
            chk("mem_addr_write", int'(mem_addr), int'(host_addr));
            chk("mem_wdata", int'(mem_wdata), int'(host_data));
         end
         if (m_pend) begin
            chk("lb_addr", int'(lb_addr), m_pidx);
            chk("lb_data", int'(lb_data), int'(m_pdat));
         end
         // statistics
         if (fetch_busy) busy_tot++;
         if (fetch_busy && !busy_prev) begin
            busy_rise = cyc;
            rise_addr = int'(mem_addr);
         end
         busy_prev = fetch_busy;
         if (lb_we) begin
            lb_cap[lb_addr] = lb_data;
            lbwe_tot++;
            if (!lb_prev) lb_rise = cyc;
            lb_last = cyc;
         end
         lb_prev = lb_we;
         if (mem_we && fetch_busy) hwb_tot++;
         // advance the model
         ok_l = (int'(line_num) < 268);
         ab   = line_req && m_busy && ok_l;
         np   = ft && !ab;
         nidx = m_next;
         ndat = mram[m_base + m_next];
         if (ew) mram[host_addr] = host_data;
         if (line_req && m_busy) m_und = 1;
         else if (underrun_clr) m_und = 0;
         if (m_busy && !m_drain) begin
            if (!host_valid || ht) m_gap = 0;
            else if (ft && m_gap < 8) m_gap++;
         end else begin
            m_gap = 0;
         end
         if (!m_busy) begin
            if (line_req && ok_l) begin
               m_busy = 1; m_base = int'(line_num) * 31; m_next = 0;
            end
         end else if (ab) begin
            m_drain = 0; m_base = int'(line_num) * 31; m_next = 0;
         end else if (m_drain) begin
            m_busy = 0; m_drain = 0;
         end else if (ft) begin
            if (m_next == 30) m_drain = 1;
            else m_next++;
         end
         m_pend = np; m_pidx = nidx; m_pdat = ndat;
      end
      cyc++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input int n);
      line_req = 1'b1;
      line_num = 9'(n);
      tick();
      line_req = 1'b0;
   endtask

   int c0, b0, w0, h0, hs;

   initial begin
      reset_ = 1'b0; line_req = 1'b0; line_num = '0; underrun_clr = 1'b0;
      host_valid = 1'b0; host_addr = '0; host_data = '0;
      repeat (3) tick();
      chk("reset_busy_lit", int'(fetch_busy), 0);
      chk("reset_lbwe_lit", int'(lb_we), 0);
      reset_ = 1'b1;
      tick();

      // line 0, no host traffic
      c0 = cyc; b0 = busy_tot; w0 = lbwe_tot;
      req(0);
      repeat (40) tick();
      chk("t1_busy_start", busy_rise - c0, 1);
      chk("t1_first_addr", rise_addr, 0);
      chk("t1_lb_first", lb_rise - c0, 2);
      chk("t1_lb_last", lb_last - c0, 32);
      chk("t1_busy_cycles", busy_tot - b0, 32);
      chk("t1_lb_writes", lbwe_tot - w0, 31);
      chk("t1_lb30", int'(lb_cap[30]), int'(pat(30)));
      chk("t1_underrun", int'(underrun), 0);

      // last visible line, then one past the end
      b0 = busy_tot;
      req(267);
      repeat (40) tick();
      chk("t2_first_addr", rise_addr, 8277);
      chk("t2_busy_cycles", busy_tot - b0, 32);
      chk("t2_lb0", int'(lb_cap[0]), int'(pat(8277)));
      chk("t2_lb30", int'(lb_cap[30]), int'(pat(8307)));
      b0 = busy_tot; w0 = lbwe_tot;
      req(268);
      repeat (40) tick();
      chk("t2_oob_busy", busy_tot - b0, 0);
      chk("t2_oob_lbwe", lbwe_tot - w0, 0);

      // line 1 with the host pushing continuously
      b0 = busy_tot; h0 = hwb_tot; hs = 0;
      req(1);
      for (int k = 0; k < 34; k++) begin
         host_valid = 1'b1;
         host_addr  = 14'(5000 + hs);
         host_data  = 16'(16'hA000 + hs);
         #2;
         if (host_ready) hs++;
         tick();
      end
      host_valid = 1'b0;
      repeat (10) tick();
      chk("t3_busy_cycles", busy_tot - b0, 35);
      chk("t3_host_writes", hwb_tot - h0, 3);
      for (int i = 0; i < 31; i++) chk("t3_lb_word", int'(lb_cap[i]), int'(pat(31 + i)));

      // host write in IDLE, then fetch the line containing it; host write in DRAIN
      host_valid = 1'b1; host_addr = 14'd40; host_data = 16'hBEEF;
      #2;
      chk("t5_idle_ready", int'(host_ready), 1);
      chk("t5_idle_we", int'(mem_we), 1);
      tick();
      host_valid = 1'b0;
      req(1);
      repeat (31) tick();
      chk("t5_drain_busy", int'(fetch_busy), 1);
      host_valid = 1'b1; host_addr = 14'd6000; host_data = 16'h1234;
      #2;
      chk("t5_drain_ready", int'(host_ready), 1);
      tick();
      host_valid = 1'b0;
      #2;
      chk("t5_after_drain_busy", int'(fetch_busy), 0);
      repeat (5) tick();
      chk("t5_lb9_new", int'(lb_cap[9]), 16'hBEEF);
      chk("t5_lb8", int'(lb_cap[8]), int'(pat(39)));

      // restart: line 6 requested while reading word 10 of line 5
      b0 = busy_tot; w0 = lbwe_tot;
      req(5);
      repeat (10) tick();
      req(6);
      repeat (40) tick();
      chk("t4_busy_cycles", busy_tot - b0, 43);
      chk("t4_lb_writes", lbwe_tot - w0, 41);
      chk("t4_underrun", int'(underrun), 1);
      for (int i = 0; i < 31; i++) chk("t4_lb_word", int'(lb_cap[i]), int'(pat(186 + i)));
      underrun_clr = 1'b1;
      tick();
      underrun_clr = 1'b0;
      chk("t4_underrun_clr", int'(underrun), 0);

      // out-of-range request while busy (set beats clear), then reset mid-fetch
      req(2);
      repeat (4) tick();
      line_req = 1'b1; line_num = 9'd300; underrun_clr = 1'b1;
      tick();
      line_req = 1'b0; underrun_clr = 1'b0;
      chk("t6_underrun_set_wins", int'(underrun), 1);
      repeat (10) tick();
      chk("t6_busy_before_rst", int'(fetch_busy), 1);
      reset_ = 1'b0;
      #1;
      chk("t6_rst_busy", int'(fetch_busy), 0);
      chk("t6_rst_lbwe", int'(lb_we), 0);
      chk("t6_rst_we", int'(mem_we), 0);
      chk("t6_rst_underrun", int'(underrun), 0);
      tick();
      tick();
      reset_ = 1'b1;
      b0 = busy_tot; w0 = lbwe_tot;
      repeat (40) tick();
      chk("t6_post_busy", busy_tot - b0, 0);
      chk("t6_post_lbwe", lbwe_tot - w0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
